fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
Parameters (name, default, meaning):
REQ-001 N, 32, instruction width in bits.
REQ-002 RESET_PC, 64'h0, byte address of the first fetch after reset.
REQ-003 HALT_WORD, 32'hb4000000, encoding treated as end-of-program (CBZ X0,#0 self-loop).

Ports (name  direction  width  meaning):
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 imem_addr  out  6  word address to instruction ROM; equals fetch_pc[7:2].
REQ-007 imem_q  in  N  ROM data for imem_addr, combinational and same cycle.
REQ-008 redirect  in  1  branch-taken request: flush queue and refetch.
REQ-009 redirect_pc  in  64  redirect target byte address; bits [1:0] ignored.
REQ-010 instr_valid  out  1  queue head holds a valid instruction.
REQ-011 instr_ready  in  1  consumer accepts the head this cycle.
REQ-012 instr  out  N  instruction at queue head.
REQ-013 instr_pc  out  64  byte address of instr.
REQ-014 halted  out  1  HALT state reached and queue empty.
REQ-015 icount  out  32  count of accepted instructions.

Function
REQ-016 Internal state: 64-bit fetch_pc, 2-entry FIFO of {instr, pc}, 2-bit occupancy count, FSM {FETCH, HALT}, 32-bit icount.
REQ-017 pop = instr_valid & instr_ready; instr_valid = (count != 0); instr/instr_pc show the head combinationally from registers.
REQ-018 push = (state==FETCH) & ~redirect & (count<2 | pop); a push writes {imem_q, fetch_pc} to the tail and sets fetch_pc <= fetch_pc+4 (mod 2^64).
REQ-019 Simultaneous push and pop: count unchanged, including when full (count==2); order preserved.
REQ-020 Full with no pop: no push; fetch_pc and imem_addr hold.
REQ-021 Empty: instr_valid=0; instr_ready ignored; no pop.
REQ-022 Latency: a word pushed at edge k is presented at edge k if the queue was empty (instr_valid high from cycle k+1); there is no combinational path from imem_q to instr.
REQ-023 Redirect (highest priority after reset): at the edge, queue cleared (count=0), fetch_pc <= {redirect_pc[63:2],2'b00}, state <= FETCH, no push that cycle; a pop in the same cycle still counts in icount.
REQ-024 FETCH -> HALT when the pushed word equals HALT_WORD; fetch_pc still increments for that push; no further pushes in HALT.
REQ-025 HALT -> FETCH only on redirect or reset; queue continues to drain in HALT.
REQ-026 halted = (state==HALT) & (count==0).
REQ-027 icount increments by 1 on each pop and wraps from 32'hFFFFFFFF to 0.
REQ-028 Address wrap: imem_addr uses only fetch_pc[7:2]; fetch_pc 0xFC -> 0x100 yields imem_addr 63 -> 0, with instr_pc carrying the full 64-bit value.

Reset
REQ-029 A reset edge sets fetch_pc=RESET_PC, count=0, state=FETCH, icount=0 and overrides redirect, push and pop that cycle.
REQ-030 Output values during and after a reset edge: instr_valid=0, halted=0, icount=0, imem_addr=RESET_PC[7:2].
REQ-031 Reset asserted mid-stream discards queued instructions with no pop counted; FIFO storage contents are don't-care once count=0.

Verification
REQ-032 ROM {0:8b000002, 1:8b000003, 2:b4000000}, ready=1 after reset -> instr_pc 0,4,8 on consecutive cycles; then halted=1, icount=3, imem_addr holds 3.
REQ-033 ready=0 for 5 cycles after reset -> count=2, imem_addr=2, instr_pc=0 held; ready=1 -> pcs 0,4,8,... with no gap or duplicate.
REQ-034 redirect=1, redirect_pc=0x1F, while head pc=0x4 is being popped -> next edge: queue empty, icount counts the pop, fetch_pc=0x1C; head pc=0x1C one cycle later.
REQ-035 redirect to 0xFC, ready=1 -> instr_pc 0xFC then 0x100; imem_addr 63 then 0.
REQ-036 In HALT with halted=1, redirect_pc=0x0 -> state FETCH, halted=0, pc 0 refetched; then reset mid-stream with count=2 -> instr_valid=0 and icount=0 after the edge.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: streams words from a combinational ROM into a
// 2-entry {instr, pc} queue, with branch redirect and halt-word detection.
module fetch_ctrl #(
    parameter int              N         = 32,
    parameter logic [63:0]     RESET_PC  = 64'h0,
    parameter logic [N-1:0]    HALT_WORD = N'(32'hb4000000)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [5:0]    imem_addr,
    input  logic [N-1:0]  imem_q,
    input  logic          redirect,
    input  logic [63:0]   redirect_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [N-1:0]  instr,
    output logic [63:0]   instr_pc,
    output logic          halted,
    output logic [31:0]   icount
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [63:0]    fetch_pc_r, fetch_pc_nxt_s;
    logic [1:0]     count_r, count_nxt_s;
    logic [31:0]    icount_r, icount_nxt_s;
    // Entry 0 is always the queue head; entry 1 is only meaningful when full.
    logic [N-1:0]   ent0_instr_r, ent0_instr_nxt_s;
    logic [63:0]    ent0_pc_r, ent0_pc_nxt_s;
    logic [N-1:0]   ent1_instr_r, ent1_instr_nxt_s;
    logic [63:0]    ent1_pc_r, ent1_pc_nxt_s;

    logic           pop_s;
    logic           push_s;

    assign pop_s  = (count_r != 2'd0) && instr_ready;
    assign push_s = (state_r == ST_FETCH) && !redirect && ((count_r != 2'd2) || pop_s);

    // Next-state logic for FSM, fetch pointer, queue storage and counters.
    always_comb begin
        state_nxt_s      = state_r;
        fetch_pc_nxt_s   = fetch_pc_r;
        count_nxt_s      = count_r;
        ent0_instr_nxt_s = ent0_instr_r;
        ent0_pc_nxt_s    = ent0_pc_r;
        ent1_instr_nxt_s = ent1_instr_r;
        ent1_pc_nxt_s    = ent1_pc_r;
        icount_nxt_s     = icount_r;

        if (pop_s) begin
            icount_nxt_s = icount_r + 32'd1;
        end else begin
            icount_nxt_s = icount_r;
        end

        if (redirect) begin
            state_nxt_s    = ST_FETCH;
            fetch_pc_nxt_s = {redirect_pc[63:2], 2'b00};
            count_nxt_s    = 2'd0;
        end else begin
            if (push_s) begin
                fetch_pc_nxt_s = fetch_pc_r + 64'd4;
                if (imem_q == HALT_WORD) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = state_r;
                end
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end

            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        ent0_instr_nxt_s = imem_q;
                        ent0_pc_nxt_s    = fetch_pc_r;
                    end else begin
                        ent1_instr_nxt_s = imem_q;
                        ent1_pc_nxt_s    = fetch_pc_r;
                    end
                    count_nxt_s = count_r + 2'd1;
                end
                2'b01: begin
                    ent0_instr_nxt_s = ent1_instr_r;
                    ent0_pc_nxt_s    = ent1_pc_r;
                    count_nxt_s      = count_r - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; when full the tail shifts forward.
                    if (count_r == 2'd2) begin
                        ent0_instr_nxt_s = ent1_instr_r;
                        ent0_pc_nxt_s    = ent1_pc_r;
                        ent1_instr_nxt_s = imem_q;
                        ent1_pc_nxt_s    = fetch_pc_r;
                    end else begin
                        ent0_instr_nxt_s = imem_q;
                        ent0_pc_nxt_s    = fetch_pc_r;
                    end
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // State register with synchronous reset overriding redirect, push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_FETCH;
            fetch_pc_r   <= RESET_PC;
            count_r      <= 2'd0;
            icount_r     <= 32'd0;
            ent0_instr_r <= '0;
            ent0_pc_r    <= 64'd0;
            ent1_instr_r <= '0;
            ent1_pc_r    <= 64'd0;
        end else begin
            state_r      <= state_nxt_s;
            fetch_pc_r   <= fetch_pc_nxt_s;
            count_r      <= count_nxt_s;
            icount_r     <= icount_nxt_s;
            ent0_instr_r <= ent0_instr_nxt_s;
            ent0_pc_r    <= ent0_pc_nxt_s;
            ent1_instr_r <= ent1_instr_nxt_s;
            ent1_pc_r    <= ent1_pc_nxt_s;
        end
    end

    assign imem_addr   = fetch_pc_r[7:2];
    assign instr_valid = (count_r != 2'd0);
    assign instr       = ent0_instr_r;
    assign instr_pc    = ent0_pc_r;
    assign halted      = (state_r == ST_HALT) && (count_r == 2'd0);
    assign icount      = icount_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed sequences push expected {instr, pc}
// pairs; a negedge monitor checks every accepted head against them.
module tb_fetch_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [5:0]   imem_addr;
    logic [31:0]  imem_q;
    logic         redirect;
    logic [63:0]  redirect_pc;
    logic         instr_valid;
    logic         instr_ready;
    logic [31:0]  instr;
    logic [63:0]  instr_pc;
    logic         halted;
    logic [31:0]  icount;

    logic [31:0]  rom [64];
    logic [95:0]  exp_q [$];
    int           checks = 0;
    int           failures = 0;

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .halted      (halted),
        .icount      (icount)
    );

    always #5 clk = ~clk;

    assign imem_q = rom[imem_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [63:0] pc);
        exp_q.push_back({rom[pc[7:2]], pc});
    endtask

    task automatic do_reset(input logic rdy);
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 64'd0;
        instr_ready = rdy;
        tick();
        tick();
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_icount", {32'd0, icount}, 64'd0);
        chk("rst_imem_addr", {58'd0, imem_addr}, 64'd0);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every accepted head must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected actual pc=0x%0h instr=0x%0h expected none", instr_pc, instr);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                if ({instr, instr_pc} !== e) begin
                    failures++;
                    $display("FAIL pop_head actual instr=0x%0h pc=0x%0h expected instr=0x%0h pc=0x%0h",
                             instr, instr_pc, e[95:64], e[63:0]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom[i] = 32'h91000000 + 32'(i);
        end
        rom[0] = 32'h8b000002;
        rom[1] = 32'h8b000003;
        rom[2] = 32'hb4000000;

        // Straight-line program ending in the halt word.
        do_reset(1'b1);
        expect_pc(64'h0);
        expect_pc(64'h4);
        expect_pc(64'h8);
        repeat (5) tick();
        chk("t1_halted", {63'd0, halted}, 64'd1);
        chk("t1_icount", {32'd0, icount}, 64'd3);
        chk("t1_imem_addr", {58'd0, imem_addr}, 64'd3);
        chk("t1_drained", 64'(exp_q.size()), 64'd0);

        // Back-pressure fills the queue, then full push+pop streams on.
        do_reset(1'b0);
        repeat (5) tick();
        chk("t2_valid", {63'd0, instr_valid}, 64'd1);
        chk("t2_imem_addr", {58'd0, imem_addr}, 64'd2);
        chk("t2_head_pc", instr_pc, 64'h0);
        expect_pc(64'h0);
        expect_pc(64'h4);
        expect_pc(64'h8);
        instr_ready = 1'b1;
        repeat (5) tick();
        chk("t2_halted", {63'd0, halted}, 64'd1);
        chk("t2_icount", {32'd0, icount}, 64'd3);
        chk("t2_drained", 64'(exp_q.size()), 64'd0);

        // Redirect while the pc=4 head is being popped.
        do_reset(1'b1);
        expect_pc(64'h0);
        expect_pc(64'h4);
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h1F;
        tick();
        redirect = 1'b0;
        chk("t3_valid", {63'd0, instr_valid}, 64'd0);
        chk("t3_icount", {32'd0, icount}, 64'd2);
        chk("t3_imem_addr", {58'd0, imem_addr}, 64'd7);
        expect_pc(64'h1C);
        expect_pc(64'h20);
        expect_pc(64'h24);
        tick();
        chk("t3_head_pc", instr_pc, 64'h1C);
        repeat (3) tick();
        instr_ready = 1'b0;
        chk("t3_icount_end", {32'd0, icount}, 64'd5);
        chk("t3_drained", 64'(exp_q.size()), 64'd0);

        // Redirect to the top of the ROM window and wrap the word address.
        do_reset(1'b1);
        redirect    = 1'b1;
        redirect_pc = 64'hFC;
        tick();
        redirect = 1'b0;
        chk("t4_addr_fc", {58'd0, imem_addr}, 64'd63);
        expect_pc(64'hFC);
        expect_pc(64'h100);
        expect_pc(64'h104);
        expect_pc(64'h108);
        tick();
        chk("t4_addr_wrap", {58'd0, imem_addr}, 64'd0);
        repeat (5) tick();
        chk("t4_halted", {63'd0, halted}, 64'd1);
        chk("t4_icount", {32'd0, icount}, 64'd4);
        chk("t4_drained", 64'(exp_q.size()), 64'd0);

        // Leave HALT via redirect, fill the queue, then reset mid-stream.
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'h0;
        tick();
        redirect = 1'b0;
        chk("t5_unhalted", {63'd0, halted}, 64'd0);
        repeat (3) tick();
        chk("t5_valid_full", {63'd0, instr_valid}, 64'd1);
        chk("t5_head_pc", instr_pc, 64'h0);
        chk("t5_imem_addr", {58'd0, imem_addr}, 64'd2);
        reset = 1'b1;
        tick();
        chk("t5_rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("t5_rst_icount", {32'd0, icount}, 64'd0);
        chk("t5_rst_halted", {63'd0, halted}, 64'd0);
        reset = 1'b0;
        tick();
        chk("t5_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
